// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches an instruction via MAR/MDR with a
// memory-ready handshake, then steps one-cycle T-states that drive the
// datapath enables for each ALU instruction class.
module control_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_WIDTH  = 5,
    parameter int REG_SEL_WIDTH = 4,
    parameter int REG_COUNT     = 16,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                    Clock,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   IR,
    input  logic                    mem_ready,
    input  logic                    run_en,
    output logic                    PCout,
    output logic                    MARin,
    output logic                    IncPC,
    output logic                    PCin,
    output logic                    Read,
    output logic                    MDRin,
    output logic                    MDRout,
    output logic                    IRin,
    output logic                    Yin,
    output logic                    Zin,
    output logic                    Zlowout,
    output logic                    Zhighout,
    output logic                    Cout,
    output logic                    HIin,
    output logic                    LOin,
    output logic [REG_COUNT-1:0]    Rin,
    output logic [REG_COUNT-1:0]    Rout,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    Run,
    output logic                    illegal,
    output logic [COUNT_WIDTH-1:0]  instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_RR, C_IMM, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    localparam int OPC_HI = DATA_WIDTH - 1;
    localparam int RA_HI  = DATA_WIDTH - OPCODE_WIDTH - 1;
    localparam int RB_HI  = RA_HI - REG_SEL_WIDTH;
    localparam int RC_HI  = RB_HI - REG_SEL_WIDTH;
    localparam int RC_LO  = RC_HI - REG_SEL_WIDTH + 1;

    state_t                   state_q, state_d;
    logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
    logic [COUNT_WIDTH-1:0]   instr_count_q, instr_count_d;

    op_class_t                op_class;
    logic                     last_exec;
    logic [REG_SEL_WIDTH-1:0] ra, rb, rc;
    logic                     unused_ir_bits;

    assign ra = IR[RA_HI -: REG_SEL_WIDTH];
    assign rb = IR[RB_HI -: REG_SEL_WIDTH];
    assign rc = IR[RC_HI -: REG_SEL_WIDTH];
    // Immediate/offset bits below Rc are consumed by the datapath, not here.
    assign unused_ir_bits = ^IR[RC_LO-1:0];

    // Register select to one-hot; out-of-range selects drive nothing.
    function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_SEL_WIDTH-1:0] sel);
        logic [REG_COUNT-1:0] v;
        v = '0;
        if (int'(sel) < REG_COUNT) v[sel] = 1'b1;
        return v;
    endfunction

    // Map the latched opcode onto its execution class.
    function automatic op_class_t classify(input logic [OPCODE_WIDTH-1:0] op);
        case (int'(op))
            3, 4, 5, 6, 7, 8, 9, 10: return C_RR;
            11, 12, 13:              return C_IMM;
            14, 15:                  return C_MULDIV;
            16, 17:                  return C_UNARY;
            26:                      return C_NOP;
            27:                      return C_HALT;
            default:                 return C_ILLEGAL;
        endcase
    endfunction

    assign op_class    = classify(opcode_q);
    assign opcode      = opcode_q;
    assign instr_count = instr_count_q;

    // State, opcode and retired-count registers with synchronous clear.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!clear) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Flag the final execute state of the current instruction class.
    always_comb begin
        last_exec = 1'b0;
        case (state_q)
            S_T3:    last_exec = (op_class == C_NOP) || (op_class == C_HALT) ||
                                 (op_class == C_ILLEGAL);
            S_T4:    last_exec = (op_class == C_UNARY);
            S_T5:    last_exec = (op_class == C_RR) || (op_class == C_IMM);
            S_T6:    last_exec = (op_class == C_MULDIV);
            default: last_exec = 1'b0;
        endcase
    end

    // Next-state, opcode capture and retirement count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        opcode_d      = opcode_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            S_IDLE:   state_d = run_en ? S_T0 : S_IDLE;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                state_d  = S_T3;
                opcode_d = IR[OPC_HI -: OPCODE_WIDTH];
            end
            S_T3, S_T4, S_T5, S_T6: begin
                if (last_exec) begin
                    instr_count_d = instr_count_q + COUNT_WIDTH'(1);
                    if (op_class == C_HALT) state_d = S_HALTED;
                    else                    state_d = run_en ? S_T0 : S_IDLE;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore decode of datapath enables; Rin/Rout index straight from IR.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Cout     = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        illegal  = 1'b0;
        Run      = (state_q != S_IDLE) && (state_q != S_HALTED);
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_RR, C_IMM: begin Rout = onehot(rb); Yin = 1'b1; end
                    C_MULDIV:    begin Rout = onehot(ra); Yin = 1'b1; end
                    C_UNARY:     begin Rout = onehot(rb); Zin = 1'b1; end
                    C_ILLEGAL:   illegal = 1'b1;
                    default:     ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_RR:     begin Rout = onehot(rc); Zin = 1'b1; end
                    C_IMM:    begin Cout = 1'b1; Zin = 1'b1; end
                    C_MULDIV: begin Rout = onehot(rb); Zin = 1'b1; end
                    C_UNARY:  begin Zlowout = 1'b1; Rin = onehot(ra); end
                    default:  ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_RR, C_IMM: begin Zlowout = 1'b1; Rin = onehot(ra); end
                    C_MULDIV:    begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:     ;
                endcase
            end
            S_T6: begin
                if (op_class == C_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
